// File: rtl/cr_clic_pkg.sv
// Shared types and helpers for the CLIC arbitration scheduler.
// A candidate is carried at fixed maximum widths so one select function serves every stage.
package cr_clic_pkg;

    localparam int unsigned LVL_MAX_W   = 8;
    localparam int unsigned ID_MAX_W    = 8;
    localparam int unsigned HOLD_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2,
        HOLD  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 vld;
        logic [LVL_MAX_W-1:0] level;
        logic [ID_MAX_W-1:0]  id;
        logic                 hv;
    } arb_cand_t;

    localparam int unsigned CAND_W = $bits(arb_cand_t);

    // Keep 'a' unless 'b' is valid and strictly higher; 'a' is always the lower index.
    function automatic arb_cand_t arb_select(input arb_cand_t a, input arb_cand_t b);
        if (b.vld && (!a.vld || (b.level > a.level))) begin
            return b;
        end
        return a;
    endfunction

    // Depth of a 4-ary reduction tree over n leaves.
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned lvls;
        int unsigned span;
        lvls = 0;
        span = 1;
        while (span < n) begin
            span = span * 4;
            lvls = lvls + 1;
        end
        return lvls;
    endfunction

endpackage

// File: rtl/cr_clic_arb_cmp4.sv
// Combinational 4-input max-select; ties resolve to the lowest input slot.
module cr_clic_arb_cmp4
    import cr_clic_pkg::*;
(
    input  logic [4*CAND_W-1:0] cands,
    output logic [CAND_W-1:0]   win
);

    arb_cand_t c0;
    arb_cand_t c1;
    arb_cand_t c2;
    arb_cand_t c3;
    arb_cand_t lo_win;
    arb_cand_t hi_win;
    arb_cand_t top_win;

    assign c0 = cands[0*CAND_W +: CAND_W];
    assign c1 = cands[1*CAND_W +: CAND_W];
    assign c2 = cands[2*CAND_W +: CAND_W];
    assign c3 = cands[3*CAND_W +: CAND_W];

    always_comb begin
        lo_win  = arb_select(c0, c1);
        hi_win  = arb_select(c2, c3);
        top_win = arb_select(lo_win, hi_win);
    end

    assign win = top_win;

endmodule

// File: rtl/cr_clic_arb_sched.sv
// CLIC arbitration scheduler: two-stage registered max tree feeding a valid/ack offer FSM
// that returns a one-cycle acknowledge to the winning kid.
module cr_clic_arb_sched
    import cr_clic_pkg::*;
#(
    parameter int unsigned INT_NUM = 64,
    parameter int unsigned CTLBITS = 3,
    parameter int unsigned ID_W    = $clog2(INT_NUM)
) (
    input  logic                           forever_cpuclk,
    input  logic                           cpurst,
    input  logic [INT_NUM-1:0]             kid_arb_int_req,
    input  logic [INT_NUM*(CTLBITS+1)-1:0] kid_arb_int_all,
    input  logic [INT_NUM-1:0]             kid_arb_int_hv,
    input  logic [CTLBITS:0]               ctrl_arb_thresh,
    input  logic                           ctrl_arb_flush,
    input  logic                           cpu_arb_int_ack,
    output logic                           arb_cpu_int_vld,
    output logic [ID_W-1:0]                arb_cpu_int_id,
    output logic [CTLBITS:0]               arb_cpu_int_level,
    output logic                           arb_cpu_int_hv,
    output logic [INT_NUM-1:0]             arb_kid_ack_int
);

    localparam int unsigned LW     = CTLBITS + 1;
    localparam int unsigned GROUPS = INT_NUM / 4;
    localparam int unsigned LEVELS = clog4(GROUPS);

    logic [INT_NUM*CAND_W-1:0] kid_cands;
    logic [GROUPS*CAND_W-1:0]  grp_win;
    logic [GROUPS*CAND_W-1:0]  grp_q;
    logic [INT_NUM-1:0]        req_q;
    arb_cand_t                 root;
    arb_cand_t                 cand_d;
    arb_cand_t                 cand_q;

    arb_state_e                state_q;
    arb_state_e                state_d;
    logic [1:0]                cnt_q;
    logic [1:0]                cnt_d;
    arb_cand_t                 out_q;
    arb_cand_t                 out_d;
    logic [INT_NUM-1:0]        ack_q;
    logic [INT_NUM-1:0]        ack_d;

    // Widen every kid into a candidate record.
    for (genvar i = 0; i < INT_NUM; i++) begin : g_kid
        arb_cand_t c;
        assign c.vld   = kid_arb_int_req[i];
        assign c.level = LVL_MAX_W'(kid_arb_int_all[i*LW +: LW]);
        assign c.id    = ID_MAX_W'(i);
        assign c.hv    = kid_arb_int_hv[i];
        assign kid_cands[i*CAND_W +: CAND_W] = c;
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        cr_clic_arb_cmp4 u_grp_cmp (
            .cands (kid_cands[g*4*CAND_W +: 4*CAND_W]),
            .win   (grp_win[g*CAND_W +: CAND_W])
        );
    end

    // Final tree over the group registers, padded with invalid leaves to a power of four.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned N = 32'd1 << (2 * (LEVELS - k));
        logic [N*CAND_W-1:0] node;
        if (k == 0) begin : g_leaf
            assign node = (N*CAND_W)'(grp_q);
        end else begin : g_cmp
            for (genvar i = 0; i < N; i++) begin : g_node
                cr_clic_arb_cmp4 u_tree_cmp (
                    .cands (g_lvl[k-1].node[i*4*CAND_W +: 4*CAND_W]),
                    .win   (node[i*CAND_W +: CAND_W])
                );
            end
        end
    end

    assign root = g_lvl[LEVELS].node;

    always_comb begin
        cand_d     = root;
        cand_d.vld = root.vld && (root.level > LVL_MAX_W'(ctrl_arb_thresh));
    end

    // req_q tracks the group stage so a withdraw never races a stale candidate.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            grp_q  <= '0;
            cand_q <= '0;
            req_q  <= '0;
        end else if (ctrl_arb_flush) begin
            grp_q  <= '0;
            cand_q <= '0;
            req_q  <= kid_arb_int_req;
        end else begin
            grp_q  <= grp_win;
            cand_q <= cand_d;
            req_q  <= kid_arb_int_req;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (cand_q.vld) begin
                    out_d   = cand_q;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (cpu_arb_int_ack) begin
                    ack_d[out_q.id[ID_W-1:0]] = 1'b1;
                    out_d   = '0;
                    state_d = ACK;
                end else if (cand_q.vld && (cand_q.level > out_q.level)) begin
                    out_d = cand_q;
                end else if (!req_q[out_q.id[ID_W-1:0]]) begin
                    out_d   = '0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == 2'(HOLD_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (ctrl_arb_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
            ack_d   = '0;
        end
    end

    if (ID_W < ID_MAX_W) begin : g_id_pad
        logic unused_id_bits;
        assign unused_id_bits = ^out_q.id[ID_MAX_W-1:ID_W];
    end

    assign arb_cpu_int_vld   = out_q.vld;
    assign arb_cpu_int_id    = out_q.id[ID_W-1:0];
    assign arb_cpu_int_level = out_q.level[LW-1:0];
    assign arb_cpu_int_hv    = out_q.hv;
    assign arb_kid_ack_int   = ack_q;

endmodule

// File: tb/tb_cr_clic_arb_sched.sv
// Directed bench for cr_clic_arb_sched: cycle-exact checks plus an offer/ack scoreboard.
module tb_cr_clic_arb_sched;

    localparam int unsigned INT_NUM = 64;
    localparam int unsigned CTLBITS = 3;
    localparam int unsigned LW      = CTLBITS + 1;
    localparam int unsigned ID_W    = 6;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [LW-1:0]   lvl;
        logic            hv;
    } offer_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [INT_NUM-1:0]    req;
    logic [INT_NUM*LW-1:0] kid_all;
    logic [INT_NUM-1:0]    hv;
    logic [LW-1:0]         thresh;
    logic                  flush;
    logic                  ack;
    logic                  vld;
    logic [ID_W-1:0]       id;
    logic [LW-1:0]         lvl;
    logic                  ohv;
    logic [INT_NUM-1:0]    kack;

    offer_t                exp_offer[$];
    logic [INT_NUM-1:0]    exp_ack[$];
    int unsigned           total  = 0;
    int unsigned           passed = 0;
    logic                  prev_vld;
    logic [ID_W-1:0]       prev_id;

    always #5 clk = ~clk;

    cr_clic_arb_sched #(
        .INT_NUM (INT_NUM),
        .CTLBITS (CTLBITS)
    ) dut (
        .forever_cpuclk    (clk),
        .cpurst            (rst),
        .kid_arb_int_req   (req),
        .kid_arb_int_all   (kid_all),
        .kid_arb_int_hv    (hv),
        .ctrl_arb_thresh   (thresh),
        .ctrl_arb_flush    (flush),
        .cpu_arb_int_ack   (ack),
        .arb_cpu_int_vld   (vld),
        .arb_cpu_int_id    (id),
        .arb_cpu_int_level (lvl),
        .arb_cpu_int_hv    (ohv),
        .arb_kid_ack_int   (kack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_kid(input int i, input logic [LW-1:0] l, input logic r, input logic h);
        req[i]              = r;
        hv[i]               = h;
        kid_all[i*LW +: LW] = r ? l : '0;
    endtask

    task automatic push_offer(input int i, input logic [LW-1:0] l, input logic h);
        offer_t o;
        o.id  = ID_W'(i);
        o.lvl = l;
        o.hv  = h;
        exp_offer.push_back(o);
    endtask

    task automatic push_ack(input int i);
        logic [INT_NUM-1:0] a;
        a    = '0;
        a[i] = 1'b1;
        exp_ack.push_back(a);
    endtask

    // Scoreboard: every new offer (rise or preemption switch) and every ack pulse pops one entry.
    always @(negedge clk) begin
        offer_t got;
        offer_t want;
        logic [INT_NUM-1:0] want_ack;
        if (vld === 1'b1 && (prev_vld !== 1'b1 || id !== prev_id)) begin
            check("offer_expected", 64'(exp_offer.size() != 0), 64'(1));
            if (exp_offer.size() != 0) begin
                want    = exp_offer.pop_front();
                got.id  = id;
                got.lvl = lvl;
                got.hv  = ohv;
                check("offer_payload", 64'(got), 64'(want));
            end
        end
        if (kack != '0) begin
            check("ack_expected", 64'(exp_ack.size() != 0), 64'(1));
            if (exp_ack.size() != 0) begin
                want_ack = exp_ack.pop_front();
                check("ack_onehot", 64'(kack), 64'(want_ack));
            end
        end
        prev_vld = vld;
        prev_id  = id;
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        kid_all = '0;
        hv      = '0;
        thresh  = '0;
        flush   = 1'b0;
        ack     = 1'b0;
        step(2);
        check("rst_vld", 64'(vld), 64'(0));
        check("rst_id", 64'(id), 64'(0));
        check("rst_level", 64'(lvl), 64'(0));
        check("rst_hv", 64'(ohv), 64'(0));
        check("rst_kack", 64'(kack), 64'(0));
        rst = 1'b0;
        step(2);

        // Kid 5: three-stage latency, then a single-cycle ack pulse.
        set_kid(5, 4'b1010, 1'b1, 1'b1);
        push_offer(5, 4'b1010, 1'b1);
        step(2);
        check("t1_vld_before_lat", 64'(vld), 64'(0));
        step(1);
        check("t1_vld_at_lat", 64'(vld), 64'(1));
        check("t1_id", 64'(id), 64'(5));
        check("t1_level", 64'(lvl), 64'(4'b1010));
        ack = 1'b1;
        push_ack(5);
        step(1);
        ack = 1'b0;
        check("t1_kack_pulse", 64'(kack), 64'(1) << 5);
        check("t1_vld_in_ack", 64'(vld), 64'(0));
        set_kid(5, 4'b0, 1'b0, 1'b0);
        step(1);
        check("t1_kack_one_cycle", 64'(kack), 64'(0));
        step(5);
        check("t1_no_reoffer", 64'(vld), 64'(0));

        // Kids 3 and 7 tie: lowest index first, then kid 7 four cycles after the pulse.
        set_kid(3, 4'b1100, 1'b1, 1'b0);
        set_kid(7, 4'b1100, 1'b1, 1'b0);
        push_offer(3, 4'b1100, 1'b0);
        step(3);
        check("t2_tie_id", 64'(id), 64'(3));
        ack = 1'b1;
        push_ack(3);
        step(1);
        ack = 1'b0;
        check("t2_kack3", 64'(kack), 64'(1) << 3);
        set_kid(3, 4'b0, 1'b0, 1'b0);
        push_offer(7, 4'b1100, 1'b0);
        step(3);
        check("t2_hold_no_vld", 64'(vld), 64'(0));
        step(1);
        check("t2_reoffer_vld", 64'(vld), 64'(1));
        check("t2_reoffer_id", 64'(id), 64'(7));
        ack = 1'b1;
        push_ack(7);
        step(1);
        ack = 1'b0;
        set_kid(7, 4'b0, 1'b0, 1'b0);
        step(5);

        // Kid 10 offered, kid 40 preempts with no valid gap.
        set_kid(10, 4'b1001, 1'b1, 1'b0);
        push_offer(10, 4'b1001, 1'b0);
        step(3);
        check("t3_id10", 64'(id), 64'(10));
        set_kid(40, 4'b1110, 1'b1, 1'b0);
        push_offer(40, 4'b1110, 1'b0);
        step(2);
        check("t3_pre_switch_vld", 64'(vld), 64'(1));
        check("t3_pre_switch_id", 64'(id), 64'(10));
        step(1);
        check("t3_switch_vld", 64'(vld), 64'(1));
        check("t3_switch_id", 64'(id), 64'(40));
        check("t3_switch_level", 64'(lvl), 64'(4'b1110));
        ack = 1'b1;
        push_ack(40);
        step(1);
        ack = 1'b0;
        set_kid(40, 4'b0, 1'b0, 1'b0);
        push_offer(10, 4'b1001, 1'b0);
        step(4);
        check("t3_kid10_back", 64'(id), 64'(10));
        // Ack lands on the preemption edge: it goes to kid 10.
        set_kid(40, 4'b1110, 1'b1, 1'b0);
        step(2);
        ack = 1'b1;
        push_ack(10);
        step(1);
        ack = 1'b0;
        check("t3_ack_wins_kack", 64'(kack), 64'(1) << 10);
        check("t3_ack_wins_vld", 64'(vld), 64'(0));
        set_kid(10, 4'b0, 1'b0, 1'b0);
        push_offer(40, 4'b1110, 1'b0);
        step(4);
        check("t3_kid40_after_hold", 64'(id), 64'(40));
        ack = 1'b1;
        push_ack(40);
        step(1);
        ack = 1'b0;
        set_kid(40, 4'b0, 1'b0, 1'b0);
        step(5);

        // Threshold is strict: equal level never offered.
        thresh = 4'b1011;
        set_kid(2, 4'b1011, 1'b1, 1'b0);
        step(6);
        check("t4_at_thresh_vld", 64'(vld), 64'(0));
        set_kid(2, 4'b1100, 1'b1, 1'b0);
        push_offer(2, 4'b1100, 1'b0);
        step(3);
        check("t4_above_thresh_vld", 64'(vld), 64'(1));

        // Withdraw: request drop clears valid two cycles later, with no ack.
        set_kid(2, 4'b0, 1'b0, 1'b0);
        step(1);
        check("t5_vld_still", 64'(vld), 64'(1));
        step(1);
        check("t5_withdrawn", 64'(vld), 64'(0));
        step(3);
        check("t5_stays_idle", 64'(vld), 64'(0));
        check("t5_no_kack", 64'(kack), 64'(0));
        thresh = '0;

        // Flush together with ack: outputs cleared, no ack pulse, arbitration restarts.
        set_kid(20, 4'b0101, 1'b1, 1'b1);
        push_offer(20, 4'b0101, 1'b1);
        step(3);
        check("t6_offer20", 64'(id), 64'(20));
        ack   = 1'b1;
        flush = 1'b1;
        push_offer(20, 4'b0101, 1'b1);
        step(1);
        ack   = 1'b0;
        flush = 1'b0;
        check("t6_flush_vld", 64'(vld), 64'(0));
        check("t6_flush_id", 64'(id), 64'(0));
        check("t6_flush_level", 64'(lvl), 64'(0));
        check("t6_flush_kack", 64'(kack), 64'(0));
        step(2);
        check("t6_refill_no_vld", 64'(vld), 64'(0));
        step(1);
        check("t6_reoffer20", 64'(vld), 64'(1));

        // Reset while holding off.
        ack = 1'b1;
        push_ack(20);
        step(1);
        ack = 1'b0;
        check("t6_kack20", 64'(kack), 64'(1) << 20);
        set_kid(20, 4'b0, 1'b0, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_rst_vld", 64'(vld), 64'(0));
        check("t6_rst_kack", 64'(kack), 64'(0));
        set_kid(21, 4'b0011, 1'b1, 1'b0);
        push_offer(21, 4'b0011, 1'b0);
        step(3);
        check("t6_idle_after_rst", 64'(vld), 64'(1));
        check("t6_id21", 64'(id), 64'(21));
        ack = 1'b1;
        push_ack(21);
        step(1);
        ack = 1'b0;
        set_kid(21, 4'b0, 1'b0, 1'b0);
        step(6);

        check("offer_queue_drained", 64'(exp_offer.size()), 64'(0));
        check("ack_queue_drained", 64'(exp_ack.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
